// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control unit:
// state codes, opcode/funct values, ALU op codes, PC/RegDst selects.
package mc_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    // R-type funct field values
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MOVN = 6'b001011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_MOVN = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;

    // PC source and register destination selects
    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;
    localparam logic [1:0] DST_RA    = 2'b00;
    localparam logic [1:0] DST_RT    = 2'b01;
    localparam logic [1:0] DST_RD    = 2'b10;

    // True for the ALU-path instructions that really write a register;
    // anything else reaching WB_AL is an undefined encoding run as a NOP.
    function automatic logic alu_writes(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE)
            return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_MOVN, FN_SLT};
        return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI};
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// Combinational opcode/funct to ALU configuration decoder.
// Unknown encodings decode to all-zero (add, register operands).
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       sg
);

    // Table lookup of the ALU setup for each supported instruction.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        sg        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  sg = 1'b1;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
                    FN_OR:   alu_op = ALU_OR;
                    FN_AND:  alu_op = ALU_AND;
                    FN_MOVN: alu_op = ALU_MOVN;
                    FN_SLT:  begin alu_op = ALU_SLT; sg = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_LW, OP_SW: begin alu_src_b = 1'b1; sg = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;  alu_src_b = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND; alu_src_b = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT; alu_src_b = 1'b1; sg = 1'b1; end
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            // bltz compares rs against $0 with slt; datapath supplies rt=$0
            OP_BLTZ:  begin alu_op = ALU_SLT; sg = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the single-ALU MIPS-subset CPU.
// HALT is a sticky flag beside the 3-bit state register.
// Optional OVERFLOW_TRAP_EN: add/sub/addiu overflow suppresses the write,
// sets sticky exc and parks the FSM in HALT.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       sign,
    input  logic       over,
    input  logic       rtdata_iszero,
    output logic [2:0] ALUop,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       sg,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic       halted
`ifdef OVERFLOW_TRAP_EN
    ,
    output logic       exc
`endif
);

    state_t     state, state_nxt;
    logic       halt_q, halt_nxt;
    logic [2:0] dec_op;
    logic       dec_a, dec_b, dec_sg;
    logic       is_r, is_jr, is_jump, is_branch, is_ls, br_taken, trap;
    logic       unused_ok;

    mc_alu_decode u_dec (
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (dec_op),
        .alu_src_a (dec_a),
        .alu_src_b (dec_b),
        .sg        (dec_sg)
    );

    assign is_r      = (opcode == OP_RTYPE);
    assign is_jr     = is_r && (funct == FN_JR);
    assign is_jump   = is_jr || (opcode == OP_J) || (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLTZ);
    assign is_ls     = (opcode == OP_LW) || (opcode == OP_SW);
    // zero is high when the ALU result is nonzero; for bltz the slt result
    // is 1 exactly when rs is negative, so nonzero means taken.
    assign br_taken  = ((opcode == OP_BEQ)  && !zero) ||
                       ((opcode == OP_BNE)  &&  zero) ||
                       ((opcode == OP_BLTZ) &&  zero);
    assign halted    = halt_q;

`ifdef OVERFLOW_TRAP_EN
    assign trap = (state == S_WB_AL) && !halt_q && over &&
                  ((is_r && (funct == FN_ADD || funct == FN_SUB)) || opcode == OP_ADDIU);
    assign unused_ok = sign;
`else
    assign trap = 1'b0;
    assign unused_ok = ^{sign, over};
`endif

    // State and halt flag registers; reset returns to IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IF;
            halt_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            halt_q <= halt_nxt;
        end
    end

`ifdef OVERFLOW_TRAP_EN
    // Sticky overflow exception flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) exc <= 1'b0;
        else if (trap) exc <= 1'b1;
    end
`endif

    // Next-state and control outputs from state, opcode and funct.
    always_comb begin
        state_nxt = state;
        halt_nxt  = halt_q;
        ALUop     = ALU_ADD;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        sg        = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = PC_NEXT;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = DST_RA;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        if (!halt_q) begin
            if (state != S_IF) begin
                ALUop   = dec_op;
                ALUSrcA = dec_a;
                ALUSrcB = dec_b;
                sg      = dec_sg;
            end
            case (state)
                S_IF: begin
                    IRWre     = 1'b1;
                    InsMemRW  = 1'b1;
                    state_nxt = S_ID;
                end
                S_ID: begin
                    if (opcode == HALT_OP) begin
                        halt_nxt  = 1'b1;
                        state_nxt = S_IF;
                    end else if (is_jump) begin
                        PCWre     = 1'b1;
                        PCSrc     = is_jr ? PC_RS : PC_JUMP;
                        state_nxt = S_IF;
                        if (opcode == OP_JAL) RegWre = 1'b1;
                    end else if (is_branch) begin
                        state_nxt = S_EXE_BR;
                    end else if (is_ls) begin
                        state_nxt = S_EXE_LS;
                    end else begin
                        state_nxt = S_EXE_AL;
                    end
                end
                S_EXE_AL: state_nxt = S_WB_AL;
                S_WB_AL: begin
                    RegWre    = alu_writes(opcode, funct) &&
                                !(is_r && funct == FN_MOVN && rtdata_iszero) && !trap;
                    RegDst    = is_r ? DST_RD : DST_RT;
                    WrRegDSrc = 1'b1;
                    PCWre     = !trap;
                    halt_nxt  = trap;
                    state_nxt = S_IF;
                end
                S_EXE_BR: begin
                    PCWre     = 1'b1;
                    PCSrc     = br_taken ? PC_BRANCH : PC_NEXT;
                    state_nxt = S_IF;
                end
                S_EXE_LS: state_nxt = S_MEM;
                S_MEM: begin
                    if (opcode == OP_SW) begin
                        mWR       = 1'b1;
                        PCWre     = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        mRD       = 1'b1;
                        state_nxt = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    RegDst    = DST_RT;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                    state_nxt = S_IF;
                end
                default: state_nxt = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction cycle model compared
// every cycle, plus literal expectations on captured cycles.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] O_R = 6'h00, O_ADDIU = 6'h09, O_ANDI = 6'h0c, O_ORI = 6'h0d,
                           O_SLTI = 6'h0a, O_LW = 6'h23, O_SW = 6'h2b, O_BEQ = 6'h04,
                           O_BNE = 6'h05, O_BLTZ = 6'h01, O_J = 6'h02, O_JAL = 6'h03,
                           O_HALT = 6'h3f;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_SLL = 6'h00, F_JR = 6'h08, F_MOVN = 6'h0b, F_SLT = 6'h2a;
`ifdef OVERFLOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] aluop;
        logic       srca, srcb, sg, pcwre;
        logic [1:0] pcsrc;
        logic       irwre, insmem, regwre;
        logic [1:0] regdst;
        logic       wrsrc, dbsrc, mrd, mwr, halted;
    } ov_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, sign = 1'b0, over = 1'b0, rtdata_iszero = 1'b0;
    logic [2:0] ALUop;
    logic       ALUSrcA, ALUSrcB, sg, PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc;
    logic       mRD, mWR, halted;
    logic [1:0] PCSrc, RegDst;
`ifdef OVERFLOW_TRAP_EN
    logic       exc;
`endif
    ov_t        got, rst_vec;
    ov_t        cap [0:15];
    int         checks = 0, failures = 0, k = 0, n_instr = 0;
    bit         active = 1'b0;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(rst), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
        .over(over), .rtdata_iszero(rtdata_iszero), .ALUop(ALUop), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .sg(sg), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .InsMemRW(InsMemRW), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .halted(halted)
`ifdef OVERFLOW_TRAP_EN
        , .exc(exc)
`endif
    );

    always #5 clk = ~clk;

    assign got = {ALUop, ALUSrcA, ALUSrcB, sg, PCWre, PCSrc, IRWre, InsMemRW, RegWre,
                  RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, halted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Cycles from fetch to completion, taken straight from the latency table.
    function automatic int lat_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == O_J || op == O_JAL || (op == O_R && fn == F_JR)) return 2;
        if (op == O_BEQ || op == O_BNE || op == O_BLTZ) return 3;
        if (op == O_LW) return 5;
        if (op == O_HALT) return 1000;
        return 4;
    endfunction

    // {ALUop, ALUSrcA, ALUSrcB, sg} per instruction.
    function automatic logic [5:0] alu_cfg(input logic [5:0] op, input logic [5:0] fn);
        if (op == O_R) begin
            case (fn)
                F_ADD:  return 6'b000_0_0_1;
                F_SUB:  return 6'b001_0_0_0;
                F_SLL:  return 6'b010_1_0_0;
                F_OR:   return 6'b011_0_0_0;
                F_AND:  return 6'b100_0_0_0;
                F_MOVN: return 6'b101_0_0_0;
                F_SLT:  return 6'b110_0_0_1;
                default: return 6'b0;
            endcase
        end
        case (op)
            O_ADDIU, O_LW, O_SW: return 6'b000_0_1_1;
            O_ORI:   return 6'b011_0_1_0;
            O_ANDI:  return 6'b100_0_1_0;
            O_SLTI:  return 6'b110_0_1_1;
            O_BEQ, O_BNE: return 6'b001_0_0_0;
            O_BLTZ:  return 6'b110_0_0_1;
            default: return 6'b0;
        endcase
    endfunction

    function automatic bit legal_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == O_R)
            return fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR ||
                   fn == F_SLL || fn == F_MOVN || fn == F_SLT;
        return op == O_ADDIU || op == O_ANDI || op == O_ORI || op == O_SLTI;
    endfunction

    // Expected outputs in cycle k (0 = fetch) of one instruction.
    function automatic ov_t exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input logic rz, input logic ov, input int k);
        ov_t e = '0;
        bit  rtype = (op == O_R);
        bit  trap = TRAP_EN && ov && ((rtype && (fn == F_ADD || fn == F_SUB)) || op == O_ADDIU);
        int  lat = trap ? 1000 : lat_of(op, fn);
        if (k == 0) begin e.irwre = 1'b1; e.insmem = 1'b1; return e; end
        if ((op == O_HALT && k >= 2) || (trap && k >= 4)) begin e.halted = 1'b1; return e; end
        {e.aluop, e.srca, e.srcb, e.sg} = alu_cfg(op, fn);
        if (k == lat - 1) begin
            e.pcwre = 1'b1;
            if (op == O_J || op == O_JAL) e.pcsrc = 2'b11;
            else if (rtype && fn == F_JR) e.pcsrc = 2'b10;
            else if ((op == O_BEQ && !z) || (op == O_BNE && z) || (op == O_BLTZ && z))
                e.pcsrc = 2'b01;
        end
        if (op == O_JAL) begin
            if (k == 1) e.regwre = 1'b1;
        end else if (op == O_LW) begin
            if (k == 3) e.mrd = 1'b1;
            if (k == 4) begin e.regwre = 1'b1; e.regdst = 2'b01; e.dbsrc = 1'b1; e.wrsrc = 1'b1; end
        end else if (op == O_SW) begin
            if (k == 3) e.mwr = 1'b1;
        end else if ((lat == 4 || trap) && k == 3) begin
            e.wrsrc  = 1'b1;
            e.regdst = rtype ? 2'b10 : 2'b01;
            e.regwre = legal_alu(op, fn) && !(rtype && fn == F_MOVN && rz) && !trap;
        end
        return e;
    endfunction

    // Every-cycle comparison against the model while an instruction is tracked.
    always @(negedge clk) begin
        if (active && !rst)
            chk($sformatf("instr%0d_cyc%0d", n_instr, k), got,
                exp_vec(opcode, funct, zero, rtdata_iszero, over, k));
    end

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic rz, input logic ov, input int n);
        opcode = op; funct = fn; zero = z; rtdata_iszero = rz; over = ov;
        n_instr++;
        active = 1'b1;
        for (int i = 0; i < n; i++) begin
            k = i;
            @(negedge clk);
            cap[i] = got;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rz, input logic ov);
        issue(op, fn, z, rz, ov, lat_of(op, fn));
    endtask

    task automatic do_reset();
        active = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int pulses(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(cap[i].pcwre);
        return c;
    endfunction

    initial begin
        rst_vec = '0;
        rst_vec.irwre = 1'b1;
        rst_vec.insmem = 1'b1;
        #3 chk("reset_outputs", got, rst_vec);
        @(posedge clk);
        #1 rst = 1'b0;

        run(O_R, F_ADD, 1'b1, 1'b0, 1'b0);
        chk("add_aluop", cap[1].aluop, 3'b000);
        chk("add_regdst", cap[3].regdst, 2'b10);
        chk("add_regwre_c4", cap[3].regwre, 1'b1);
        chk("add_regwre_early", {cap[0].regwre, cap[1].regwre, cap[2].regwre}, 3'b000);
        chk("add_pcwre_c4", cap[3].pcwre, 1'b1);
        chk("add_pcwre_count", pulses(4), 1);

        run(O_BEQ, 6'h00, 1'b0, 1'b0, 1'b0);
        chk("beq_pcsrc", cap[2].pcsrc, 2'b01);
        chk("beq_pcwre", cap[2].pcwre, 1'b1);
        run(O_BNE, 6'h00, 1'b0, 1'b0, 1'b0);
        chk("bne_pcsrc", cap[2].pcsrc, 2'b00);
        chk("bne_pcwre", cap[2].pcwre, 1'b1);

        run(O_LW, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("lw_mrd", cap[3].mrd, 1'b1);
        chk("lw_wb", {cap[4].dbsrc, cap[4].regdst, cap[4].regwre}, 4'b1_01_1);
        chk("lw_pcwre_count", pulses(5), 1);
        run(O_SW, 6'h00, 1'b1, 1'b0, 1'b0);
        chk("sw_mem", {cap[3].mwr, cap[3].pcwre}, 2'b11);

        run(O_JAL, 6'h00, 1'b0, 1'b0, 1'b0);
        chk("jal_id", {cap[1].regdst, cap[1].wrsrc, cap[1].pcsrc, cap[1].regwre}, 6'b00_0_11_1);
        run(O_R, F_MOVN, 1'b0, 1'b1, 1'b0);
        chk("movn_nowrite", cap[3].regwre, 1'b0);

        // Remaining encodings checked by the model alone
        run(O_R, F_MOVN, 1'b1, 1'b0, 1'b0);
        run(O_R, F_SUB,  1'b1, 1'b0, 1'b0);
        run(O_R, F_SLL,  1'b1, 1'b0, 1'b0);
        run(O_R, F_OR,   1'b1, 1'b0, 1'b0);
        run(O_R, F_AND,  1'b1, 1'b0, 1'b0);
        run(O_R, F_SLT,  1'b0, 1'b0, 1'b0);
        run(O_ADDIU, 6'h00, 1'b1, 1'b0, 1'b0);
        run(O_ORI,   6'h00, 1'b1, 1'b0, 1'b0);
        run(O_ANDI,  6'h00, 1'b1, 1'b0, 1'b0);
        run(O_SLTI,  6'h00, 1'b0, 1'b0, 1'b0);
        run(O_BEQ,   6'h00, 1'b1, 1'b0, 1'b0);
        run(O_BNE,   6'h00, 1'b1, 1'b0, 1'b0);
        run(O_BLTZ,  6'h00, 1'b1, 1'b0, 1'b0);
        run(O_BLTZ,  6'h00, 1'b0, 1'b0, 1'b0);
        run(O_J,     6'h00, 1'b0, 1'b0, 1'b0);
        run(O_R,     F_JR,  1'b0, 1'b0, 1'b0);
        run(6'h3a,   6'h00, 1'b0, 1'b0, 1'b0);
        run(O_R,     6'h3f, 1'b0, 1'b0, 1'b0);
        chk("undef_funct_nowrite", cap[3].regwre, 1'b0);

        // Overflowing add: written unless the trap is built in
        run(O_R, F_ADD, 1'b1, 1'b0, 1'b1);
`ifndef OVERFLOW_TRAP_EN
        chk("ovf_add_writes", cap[3].regwre, 1'b1);
`else
        chk("trap_wb", {cap[3].regwre, cap[3].pcwre}, 2'b00);
        chk("trap_halted", cap[4].halted, 1'b1);
        chk("trap_exc", exc, 1'b1);
        do_reset();
        chk("exc_cleared", exc, 1'b0);
`endif

        // Asynchronous reset in EXE_AL of an add
        issue(O_R, F_ADD, 1'b1, 1'b0, 1'b0, 2);
        #1 active = 1'b0;
        rst = 1'b1;
        #1 chk("async_reset_mid_add", got, rst_vec);
        @(posedge clk);
        #1 rst = 1'b0;
        run(O_R, F_ADD, 1'b1, 1'b0, 1'b0);
        chk("add_after_reset", cap[3].regwre, 1'b1);

        // HALT then 10 more clocks
        issue(O_HALT, 6'h00, 1'b0, 1'b0, 1'b0, 12);
        chk("halt_flag", cap[11].halted, 1'b1);
        chk("halt_no_pcwre", pulses(12), 0);
        do_reset();
        chk("halt_cleared", halted, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
